// File: rtl/gpio_in_filter_pkg.sv
// Board-level constants for the DE0-Nano hm2 GPIO path.
// Also holds the hm2-bit to header-pin mapping that the input filter and the output mux share.
package gpio_in_filter_pkg;

    localparam int GPIOWidth      = 36;
    localparam int NumGPIO        = 1;
    localparam int IOWidth        = 34;
    localparam int MuxGPIOIOWidth = IOWidth / NumGPIO;
    localparam int FiltWidth      = 8;
    localparam int NumPins        = GPIOWidth * NumGPIO;

    // Each header supplies MuxGPIOIOWidth consecutive hm2 bits, starting at its pin 0.
    function automatic int hm2_pin_index(input int bit_idx);
        return (bit_idx / MuxGPIOIOWidth) * GPIOWidth + (bit_idx % MuxGPIOIOWidth);
    endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// Signal bundle between the header pads and host logic and the hm2 input filter.
// There is no valid/ready pairing: every signal is a level that clk samples on each rising edge.
interface gpio_in_filter_if
    import gpio_in_filter_pkg::*;
();

    logic [NumPins-1:0]   gpio_in;
    logic [FiltWidth-1:0] filt_len;
    logic [IOWidth-1:0]   evt_clr;
    logic [IOWidth-1:0]   hm2_in;
    logic [IOWidth-1:0]   edge_evt;
    logic                 evt_any;

    modport master (
        output gpio_in, filt_len, evt_clr,
        input  hm2_in, edge_evt, evt_any
    );

    modport slave (
        input  gpio_in, filt_len, evt_clr,
        output hm2_in, edge_evt, evt_any
    );

endinterface

// File: rtl/gpio_in_filter_bit.sv
// One header pin: a two-flop synchronizer followed by a debounce counter.
// toggle_o is high during the cycle whose rising edge updates stable_o.
module gpio_in_filter_bit
    import gpio_in_filter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pin_i,
    input  logic [FiltWidth-1:0] filt_len_i,
    output logic                 stable_o,
    output logic                 toggle_o
);

    logic                 s1_q;
    logic                 s2_q;
    logic                 stable_q;
    logic                 stable_d;
    logic [FiltWidth-1:0] cnt_q;
    logic [FiltWidth-1:0] cnt_d;
    logic                 accept;

    // The >= compare means a lowered filt_len accepts at once when cnt already reaches it.
    assign accept = (s2_q != stable_q) && (cnt_q >= filt_len_i);

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (accept) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= pin_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign toggle_o = accept;

endmodule

// File: rtl/gpio_in_filter.sv
// hm2 input path: per-pin filters, mapping onto the IOBits vector, and sticky change events.
// Header pins outside the mapping are still filtered but feed nothing.
module gpio_in_filter
    import gpio_in_filter_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    gpio_in_filter_if.slave bus
);

    logic [NumPins-1:0] pin_stable;
    logic [NumPins-1:0] pin_toggle;
    logic [IOWidth-1:0] map_stable;
    logic [IOWidth-1:0] map_toggle;
    logic [IOWidth-1:0] edge_evt_q;
    logic [IOWidth-1:0] edge_evt_d;
    logic               evt_any_q;
    logic               evt_any_d;
    logic               unused_pins;

    for (genvar p = 0; p < NumPins; p++) begin : g_pin
        gpio_in_filter_bit u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .pin_i      (bus.gpio_in[p]),
            .filt_len_i (bus.filt_len),
            .stable_o   (pin_stable[p]),
            .toggle_o   (pin_toggle[p])
        );
    end

    for (genvar i = 0; i < IOWidth; i++) begin : g_map
        localparam int Pin = hm2_pin_index(i);
        assign map_stable[i] = pin_stable[Pin];
        assign map_toggle[i] = pin_toggle[Pin];
    end

    assign unused_pins = ^{pin_stable, pin_toggle};

    // A toggle on the same edge as a clear leaves the flag set.
    always_comb begin
        edge_evt_d = (edge_evt_q & ~bus.evt_clr) | map_toggle;
        evt_any_d  = |edge_evt_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_evt_q <= '0;
            evt_any_q  <= 1'b0;
        end else begin
            edge_evt_q <= edge_evt_d;
            evt_any_q  <= evt_any_d;
        end
    end

    assign bus.hm2_in   = map_stable;
    assign bus.edge_evt = edge_evt_q;
    assign bus.evt_any  = evt_any_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios plus random pin activity.
// A run-length reference model pushes expected outputs each edge and a monitor compares them.
module tb_gpio_in_filter;
    import gpio_in_filter_pkg::*;

    localparam int OW = 2 * IOWidth + 1;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gpio_in_filter_if bus_if ();

    gpio_in_filter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [OW-1:0] exp_q[$];

    function automatic void check(string name, logic [IOWidth-1:0] act, logic [IOWidth-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int map_pin(int i);
        return (i / MuxGPIOIOWidth) * GPIOWidth + (i % MuxGPIOIOWidth);
    endfunction

    // reference model: a pin's new level is accepted once it has been seen
    // (filt_len+1) times in a row at the synchronized sample
    logic [NumPins-1:0] m_s1 = '0;
    logic [NumPins-1:0] m_s2 = '0;
    logic [NumPins-1:0] m_stable = '0;
    int                 m_run[NumPins];
    logic [IOWidth-1:0] m_evt = '0;

    initial begin : model
        logic [NumPins-1:0] prev;
        logic [IOWidth-1:0] hm2;
        logic [IOWidth-1:0] tog;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_s1 = '0;
                m_s2 = '0;
                m_stable = '0;
                m_evt = '0;
                for (int p = 0; p < NumPins; p++) m_run[p] = 0;
            end else begin
                prev = m_stable;
                for (int p = 0; p < NumPins; p++) begin
                    if (m_s2[p] == m_stable[p]) begin
                        m_run[p] = 0;
                    end else begin
                        m_run[p] = m_run[p] + 1;
                        if (m_run[p] > int'(bus_if.filt_len)) begin
                            m_stable[p] = m_s2[p];
                            m_run[p] = 0;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = bus_if.gpio_in;
                for (int i = 0; i < IOWidth; i++) tog[i] = m_stable[map_pin(i)] != prev[map_pin(i)];
                m_evt = (m_evt & ~bus_if.evt_clr) | tog;
            end
            for (int i = 0; i < IOWidth; i++) hm2[i] = m_stable[map_pin(i)];
            exp_q.push_back({hm2, m_evt, |m_evt});
        end
    end

    // monitor
    initial begin : monitor
        logic [OW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_hm2_in", bus_if.hm2_in, e[OW-1 -: IOWidth]);
                check("sb_edge_evt", bus_if.edge_evt, e[IOWidth:1]);
                check("sb_evt_any", IOWidth'(bus_if.evt_any), IOWidth'(e[0]));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // driver
    initial begin
        logic [63:0] r;
        bus_if.gpio_in = '0;
        bus_if.filt_len = '0;
        bus_if.evt_clr = '0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(10);
        check("rst_hm2_in", bus_if.hm2_in, '0);
        check("rst_edge_evt", bus_if.edge_evt, '0);
        check("rst_evt_any", IOWidth'(bus_if.evt_any), '0);

        // N=0 step on pin 5: visible after the third edge
        bus_if.gpio_in[5] = 1'b1;
        tick(2);
        check("n0_edge2", IOWidth'(bus_if.hm2_in[5]), '0);
        tick(1);
        check("n0_edge3", IOWidth'(bus_if.hm2_in[5]), 1);
        check("n0_evt5", IOWidth'(bus_if.edge_evt[5]), 1);
        check("n0_any", IOWidth'(bus_if.evt_any), 1);
        bus_if.evt_clr[5] = 1'b1;
        tick(1);
        bus_if.evt_clr = '0;
        check("clr5_evt", IOWidth'(bus_if.edge_evt[5]), '0);
        check("clr5_any", IOWidth'(bus_if.evt_any), '0);

        // N=4: 3-cycle glitch rejected, 5-cycle pulse accepted
        bus_if.filt_len = 8'd4;
        bus_if.gpio_in[0] = 1'b1;
        tick(3);
        bus_if.gpio_in[0] = 1'b0;
        tick(12);
        check("glitch_hm2", IOWidth'(bus_if.hm2_in[0]), '0);
        check("glitch_evt", IOWidth'(bus_if.edge_evt[0]), '0);
        bus_if.gpio_in[0] = 1'b1;
        tick(5);
        bus_if.gpio_in[0] = 1'b0;
        tick(1);
        check("n4_edge6", IOWidth'(bus_if.hm2_in[0]), '0);
        tick(1);
        check("n4_edge7", IOWidth'(bus_if.hm2_in[0]), 1);
        tick(4);
        check("n4_fall6", IOWidth'(bus_if.hm2_in[0]), 1);
        tick(1);
        check("n4_fall7", IOWidth'(bus_if.hm2_in[0]), '0);

        // filt_len lowered mid-count accepts on the next edge
        bus_if.filt_len = 8'd200;
        bus_if.gpio_in[2] = 1'b1;
        tick(52);
        check("f200_hold", IOWidth'(bus_if.hm2_in[2]), '0);
        bus_if.filt_len = 8'd10;
        tick(1);
        check("f200_drop", IOWidth'(bus_if.hm2_in[2]), 1);

        // set beats a same-edge clear; clear elsewhere still works
        bus_if.filt_len = '0;
        bus_if.gpio_in[5] = 1'b0;
        tick(2);
        bus_if.evt_clr[5] = 1'b1;
        bus_if.evt_clr[0] = 1'b1;
        tick(1);
        bus_if.evt_clr = '0;
        check("set_wins", IOWidth'(bus_if.edge_evt[5]), 1);
        check("clr_other", IOWidth'(bus_if.edge_evt[0]), '0);
        check("keep_other", IOWidth'(bus_if.edge_evt[2]), 1);

        // unmapped header pins change nothing
        bus_if.gpio_in[35:34] = 2'b11;
        tick(10);
        check("unmapped_hm2", bus_if.hm2_in, 34'h4);
        bus_if.gpio_in[35:34] = 2'b00;
        tick(10);

        // maximum filter length
        bus_if.filt_len = 8'd255;
        bus_if.gpio_in[10] = 1'b1;
        tick(257);
        check("n255_edge257", IOWidth'(bus_if.hm2_in[10]), '0);
        tick(1);
        check("n255_edge258", IOWidth'(bus_if.hm2_in[10]), 1);

        // random activity, occasional filt_len changes and mid-run resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) bus_if.filt_len = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) bus_if.gpio_in[$urandom_range(0, NumPins - 1)] ^= 1'b1;
            r = {$urandom(), $urandom()};
            bus_if.evt_clr = ($urandom_range(0, 3) == 0) ? r[IOWidth-1:0] : '0;
            reset_n = ($urandom_range(0, 199) != 0);
            tick(1);
        end
        reset_n = 1'b1;
        bus_if.evt_clr = '0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
